// File: rtl/adc0_frame_sender.sv
// ADC0 frame sender: arms a capture, drains the capture FIFO and emits
// A5 5A CH LEN_H LEN_L <samples> CSUM over a valid/ready byte link.
module adc0_frame_sender #(
  parameter int          FRAME_LEN   = 4096,
  parameter logic [7:0]  CH_ID       = 8'h00,
  parameter int          TIMEOUT_CYC = 50000000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic       ADC0_end,
  input  logic       empty,
  input  logic [7:0] fifo_q,
  output logic       ADC0_bg,
  output logic       rdreq,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun,
  output logic       timeout
);

  localparam int              TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [15:0]     LEN    = 16'(FRAME_LEN);
  localparam logic [15:0]     LAST   = 16'(FRAME_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_HDR0, S_HDR1, S_CHID, S_LENH, S_LENL,
    S_FETCH, S_WAITQ, S_SEND, S_CSUM, S_REL
  } state_t;

  state_t        state, nxt;
  logic [TW-1:0] timer;
  logic [15:0]   cnt;
  logic [7:0]    csum;
  logic [7:0]    sample;
  logic          acc;

  assign acc = tx_valid && tx_ready;

  always_comb begin
    nxt      = state;
    ADC0_bg  = 1'b0;
    rdreq    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE: if (start) nxt = S_ARM;
      S_ARM: begin
        ADC0_bg = 1'b1;
        if (ADC0_end)            nxt = S_HDR0;
        else if (timer == T_LAST) nxt = S_IDLE;
      end
      S_HDR0: begin
        ADC0_bg = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
        if (tx_ready) nxt = S_HDR1;
      end
      S_HDR1: begin
        ADC0_bg = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
        if (tx_ready) nxt = S_CHID;
      end
      S_CHID: begin
        ADC0_bg = 1'b1; tx_valid = 1'b1; tx_data = CH_ID;
        if (tx_ready) nxt = S_LENH;
      end
      S_LENH: begin
        ADC0_bg = 1'b1; tx_valid = 1'b1; tx_data = LEN[15:8];
        if (tx_ready) nxt = S_LENL;
      end
      S_LENL: begin
        ADC0_bg = 1'b1; tx_valid = 1'b1; tx_data = LEN[7:0];
        if (tx_ready) nxt = S_FETCH;
      end
      S_FETCH: begin
        // An empty FIFO is padded with a zero sample instead of being read.
        ADC0_bg = 1'b1;
        rdreq   = !empty;
        nxt     = empty ? S_SEND : S_WAITQ;
      end
      S_WAITQ: begin
        ADC0_bg = 1'b1;
        nxt     = S_SEND;
      end
      S_SEND: begin
        ADC0_bg = 1'b1; tx_valid = 1'b1; tx_data = sample;
        if (tx_ready) nxt = (cnt == LAST) ? S_CSUM : S_FETCH;
      end
      S_CSUM: begin
        ADC0_bg = 1'b1; tx_valid = 1'b1; tx_data = csum;
        if (tx_ready) nxt = S_REL;
      end
      S_REL:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      cnt        <= '0;
      csum       <= '0;
      sample     <= '0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= nxt;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      timer      <= (state == S_ARM) ? timer + 1'b1 : '0;
      case (state)
        S_IDLE: if (start) begin
          underrun <= 1'b0;
          csum     <= '0;
          cnt      <= '0;
        end
        S_ARM: if (!ADC0_end && timer == T_LAST) timeout <= 1'b1;
        // Sync bytes A5/5A stay out of the checksum.
        S_CHID, S_LENH, S_LENL: if (acc) csum <= csum + tx_data;
        S_FETCH: if (empty) begin
          underrun <= 1'b1;
          sample   <= 8'h00;
        end
        S_WAITQ: sample <= fifo_q;
        S_SEND: if (acc) begin
          csum <= csum + sample;
          cnt  <= cnt + 16'd1;
        end
        S_CSUM: if (acc) frame_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc0_frame_sender.sv
// Directed bench for adc0_frame_sender with FRAME_LEN=4, CH_ID=3, TIMEOUT_CYC=64
// and a behavioural normal-mode FIFO.
module tb_adc0_frame_sender;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       start = 1'b0;
  logic       ADC0_end = 1'b0;
  logic       empty;
  logic [7:0] fifo_q = 8'h00;
  logic       tx_ready = 1'b1;
  logic       ADC0_bg, rdreq, tx_valid, busy, frame_done, underrun, timeout;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;

  adc0_frame_sender #(.FRAME_LEN(4), .CH_ID(8'h03), .TIMEOUT_CYC(64)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .ADC0_end(ADC0_end),
    .empty(empty), .fifo_q(fifo_q), .ADC0_bg(ADC0_bg), .rdreq(rdreq),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done), .underrun(underrun), .timeout(timeout)
  );

  always #5 Clk = ~Clk;

  // FIFO model: q is valid the cycle after rdreq
  logic [7:0] mem [256];
  int rd_ptr = 0;
  int wr_cnt = 0;
  assign empty = (rd_ptr == wr_cnt);
  always @(posedge Clk)
    if (rdreq && !empty) begin
      fifo_q <= mem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end

  // link monitor, sampled mid-cycle
  logic [7:0] log_b [256];
  int log_n = 0, rdreq_n = 0, rd_empty_n = 0, done_n = 0, done_bad = 0;
  int stall_err = 0, txv_n = 0;
  bit prev_stall = 1'b0, prev_acc = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge Clk) begin
    if (tx_valid && tx_ready) begin
      log_b[log_n % 256] <= tx_data;
      log_n <= log_n + 1;
    end
    if (rdreq) rdreq_n <= rdreq_n + 1;
    if (rdreq && empty) rd_empty_n <= rd_empty_n + 1;
    if (tx_valid) txv_n <= txv_n + 1;
    if (frame_done) begin
      done_n <= done_n + 1;
      if (!prev_acc) done_bad <= done_bad + 1;
    end
    if (prev_stall && (!tx_valid || tx_data != prev_data)) stall_err <= stall_err + 1;
    prev_acc   <= tx_valid && tx_ready;
    prev_stall <= tx_valid && !tx_ready;
    prev_data  <= tx_data;
  end

  int cyc = 0;
  bit rdy_pat = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    tx_ready = rdy_pat ? (cyc % 3 == 0) : 1'b1;
  endtask

  task automatic load(input logic [7:0] v [4], input int n);
    for (int i = 0; i < n; i++) mem[(rd_ptr + i) % 256] = v[i];
    wr_cnt = rd_ptr + n;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_outs"}, {ADC0_bg, rdreq, tx_valid, busy, frame_done, underrun, timeout}, 7'd0);
    chk({tag, "_data"}, tx_data, 8'h00);
  endtask

  // start, ADC0_end after end_dly cycles, wait for frame_done; optional stray starts
  task automatic run_frame(input string tag, input int end_dly, input bit poke);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < end_dly; i++) begin
      start = poke && (i % 5 == 0);
      tick();
    end
    start = 1'b0;
    ADC0_end = 1'b1;
    tick();
    ADC0_end = 1'b0;
    for (int i = 0; i < 300; i++) begin
      start = poke && (i % 7 == 0);
      tick();
      if (frame_done) break;
    end
    start = 1'b0;
    chk({tag, "_done"}, frame_done, 1'b1);
    chk({tag, "_rel_bg"}, ADC0_bg, 1'b0);
    chk({tag, "_rel_busy"}, busy, 1'b1);
    tick();
    chk({tag, "_idle"}, {busy, frame_done}, 2'b00);
  endtask

  task automatic chk_frame(input string tag, input int base, input logic [7:0] e [10]);
    chk({tag, "_nbytes"}, log_n - base, 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s_b%0d", tag, i), log_b[(base + i) % 256], e[i]);
  endtask

  logic [7:0] d_full [4] = '{8'h0A, 8'h14, 8'h1E, 8'h28};
  logic [7:0] d_half [4] = '{8'h07, 8'h09, 8'h00, 8'h00};
  // CSUM = 03+00+04+0A+14+1E+28 = 6B
  logic [7:0] e_full [10] = '{8'hA5, 8'h5A, 8'h03, 8'h00, 8'h04,
                              8'h0A, 8'h14, 8'h1E, 8'h28, 8'h6B};
  // CH_ID=3 here, so CSUM = 03+00+04+07+09+00+00 = 17
  logic [7:0] e_half [10] = '{8'hA5, 8'h5A, 8'h03, 8'h00, 8'h04,
                              8'h07, 8'h09, 8'h00, 8'h00, 8'h17};

  initial begin
    int base, rq0, d0, t0, k;

    // reset state
    Reset_n = 1'b0;
    repeat (3) tick();
    chk_idle_outs("rst");
    Reset_n = 1'b1;
    tick();

    // full frame, tx_ready always high
    load(d_full, 4);
    base = log_n; rq0 = rdreq_n;
    run_frame("t2", 20, 1'b0);
    chk_frame("t2", base, e_full);
    chk("t2_rdreq", rdreq_n - rq0, 4);
    chk("t2_underrun", underrun, 1'b0);

    // same frame with tx_ready high one cycle in three
    load(d_full, 4);
    base = log_n; rq0 = rdreq_n;
    rdy_pat = 1'b1;
    run_frame("t3", 20, 1'b0);
    rdy_pat = 1'b0;
    chk_frame("t3", base, e_full);
    chk("t3_rdreq", rdreq_n - rq0, 4);
    chk("t3_stall", stall_err, 0);

    // only two samples in the FIFO: zero padding and underrun
    load(d_half, 2);
    base = log_n; rq0 = rdreq_n;
    run_frame("t4", 6, 1'b0);
    chk_frame("t4", base, e_half);
    chk("t4_rdreq", rdreq_n - rq0, 2);
    chk("t4_underrun", underrun, 1'b1);
    chk("t4_rd_empty", rd_empty_n, 0);

    // ARM timeout after 64 cycles; the start also clears underrun
    t0 = txv_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_arm", {busy, ADC0_bg, underrun}, 3'b110);
    k = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      k++;
      if (timeout) break;
    end
    chk("t5_timeout", timeout, 1'b1);
    chk("t5_delay", k, 64);
    chk("t5_state", {ADC0_bg, busy}, 2'b00);
    chk("t5_txv", txv_n - t0, 0);
    tick();
    chk("t5_pulse", timeout, 1'b0);

    // stray starts during the frame and ADC0_end held in IDLE
    load(d_full, 4);
    base = log_n; rq0 = rdreq_n; d0 = done_n;
    run_frame("t6", 20, 1'b1);
    ADC0_end = 1'b1;
    repeat (20) tick();
    ADC0_end = 1'b0;
    chk_frame("t6", base, e_full);
    chk("t6_done_n", done_n - d0, 1);
    chk("t6_quiet", {busy, ADC0_bg}, 2'b00);
    chk("t6_rdreq", rdreq_n - rq0, 4);

    // reset while SEND holds the second sample, then a clean frame
    load(d_full, 4);
    base = log_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    ADC0_end = 1'b1;
    tick();
    ADC0_end = 1'b0;
    k = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx_valid && (log_n - base == 6)) break;
      tick();
      k++;
    end
    chk("t1_in_send", k < 100, 1'b1);
    Reset_n = 1'b0;
    tick();
    chk_idle_outs("t1_rst");
    Reset_n = 1'b1;
    tick();
    chk_idle_outs("t1_after");
    load(d_full, 4);
    base = log_n;
    run_frame("t1", 10, 1'b0);
    chk_frame("t1", base, e_full);

    chk("done_timing", done_bad, 0);
    chk("stall_total", stall_err, 0);
    chk("rd_empty_total", rd_empty_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
